// File: rtl/param_alu_if.sv
// Operand/control/result bundle between the register file, param_alu and writeback.
// The master side drives operands and control; the slave side (the ALU) returns results.
interface param_alu_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] a;
  logic             a_enable;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] mul_acc_out;
  logic             zero;
  logic             carry;

  modport master (
    output a, a_enable, b, op, start,
    input  busy, done, acc_out, mul_acc_out, zero, carry
  );

  modport slave (
    input  a, a_enable, b, op, start,
    output busy, done, acc_out, mul_acc_out, zero, carry
  );
endinterface

// File: rtl/param_alu.sv
// Accumulator ALU: single-cycle ADD/SUB/XOR/AND/OR plus an iterative shift-add
// unsigned multiply producing a 2*WIDTH result split across acc_out / mul_acc_out.
module param_alu #(
  parameter int unsigned WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  param_alu_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpXor = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpOr  = 3'd4;
  localparam logic [2:0] OpMul = 3'd5;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_reg_q, a_reg_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mul_acc_q, mul_acc_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]       add_sum, sub_sum, step_sum;
  logic [2*WIDTH-1:0]   prod_step;
  logic [WIDTH-1:0]     res;
  logic                 res_c;
  logic                 res_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_reg_q   <= '0;
      acc_q     <= '0;
      mul_acc_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_reg_q   <= a_reg_d;
      acc_q     <= acc_d;
      mul_acc_q <= mul_acc_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    add_sum   = {1'b0, a_reg_q} + {1'b0, bus.b};
    sub_sum   = {1'b0, a_reg_q} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    // a_reg cannot change while busy, so it serves directly as the multiplicand.
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, a_reg_q} : '0);
    prod_step = {step_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_reg_d   = a_reg_q;
    acc_d     = acc_q;
    mul_acc_d = mul_acc_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    res       = '0;
    res_c     = 1'b0;
    res_wr    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.a_enable) begin
          a_reg_d = bus.a;
        end
        if (bus.start) begin
          done_d = 1'b1;
          case (bus.op)
            OpAdd: begin
              res    = add_sum[WIDTH-1:0];
              res_c  = add_sum[WIDTH];
              res_wr = 1'b1;
            end
            OpSub: begin
              res    = sub_sum[WIDTH-1:0];
              res_c  = sub_sum[WIDTH];
              res_wr = 1'b1;
            end
            OpXor: begin
              res    = a_reg_q ^ bus.b;
              res_wr = 1'b1;
            end
            OpAnd: begin
              res    = a_reg_q & bus.b;
              res_wr = 1'b1;
            end
            OpOr: begin
              res    = a_reg_q | bus.b;
              res_wr = 1'b1;
            end
            OpMul: begin
              done_d   = 1'b0;
              state_d  = StMul;
              mplier_d = bus.b;
              prod_d   = '0;
              cnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          mul_acc_d = prod_step[WIDTH-1:0];
          res       = prod_step[2*WIDTH-1:WIDTH];
          res_c     = |prod_step[2*WIDTH-1:WIDTH];
          res_wr    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (res_wr) begin
      acc_d   = res;
      zero_d  = (res == '0);
      carry_d = res_c;
    end
  end

  assign bus.busy        = (state_q == StMul);
  assign bus.done        = done_q;
  assign bus.acc_out     = acc_q;
  assign bus.mul_acc_out = mul_acc_q;
  assign bus.zero        = zero_q;
  assign bus.carry       = carry_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu: a 16-bit and an 8-bit instance sharing clock and reset,
// checked with immediate assertions against hand-computed values.
module tb_param_alu;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  param_alu_if #(.WIDTH(16)) if16 ();
  param_alu_if #(.WIDTH(8))  if8 ();

  param_alu #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  param_alu #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load16(input logic [15:0] val);
    if16.a        = val;
    if16.a_enable = 1'b1;
    tick();
    if16.a_enable = 1'b0;
  endtask

  task automatic op16(input logic [2:0] opc, input logic [15:0] bval);
    if16.op    = opc;
    if16.b     = bval;
    if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
  endtask

  task automatic res16(input string tag, input logic [15:0] acc, input logic c,
                       input logic z);
    chk({tag, "_done"}, 32'(if16.done), 32'd1);
    chk({tag, "_acc"}, 32'(if16.acc_out), 32'(acc));
    chk({tag, "_carry"}, 32'(if16.carry), 32'(c));
    chk({tag, "_zero"}, 32'(if16.zero), 32'(z));
  endtask

  initial begin
    int bad;
    int n;
    total  = 0;
    passed = 0;
    if16.a = '0; if16.a_enable = 1'b0; if16.b = '0; if16.op = '0; if16.start = 1'b0;
    if8.a  = '0; if8.a_enable  = 1'b0; if8.b  = '0; if8.op  = '0; if8.start  = 1'b0;

    // Reset with start and a_enable held high: reset must win.
    rst = 1'b1;
    if16.start = 1'b1; if16.a_enable = 1'b1; if16.a = 16'hFFFF; if16.b = 16'h0001;
    tick();
    tick();
    rst = 1'b0;
    if16.start = 1'b0; if16.a_enable = 1'b0;
    chk("rst_acc", 32'(if16.acc_out), 32'h0);
    chk("rst_mul", 32'(if16.mul_acc_out), 32'h0);
    chk("rst_zero", 32'(if16.zero), 32'h0);
    chk("rst_carry", 32'(if16.carry), 32'h0);
    chk("rst_busy", 32'(if16.busy), 32'h0);
    chk("rst_done", 32'(if16.done), 32'h0);

    // a_reg must have reset to 0.
    op16(3'd0, 16'h0003);
    res16("add_after_rst", 16'h0003, 1'b0, 1'b0);

    load16(16'hFFFF);
    chk("done_idle", 32'(if16.done), 32'h0);
    op16(3'd0, 16'h0001);
    res16("add_wrap", 16'h0000, 1'b1, 1'b1);
    tick();
    chk("done_pulse_end", 32'(if16.done), 32'h0);

    load16(16'h7FFF);
    op16(3'd0, 16'h0001);
    res16("add_msb", 16'h8000, 1'b0, 1'b0);

    load16(16'h0005);
    op16(3'd1, 16'h0007);
    res16("sub_borrow", 16'hFFFE, 1'b0, 1'b0);

    load16(16'h0007);
    op16(3'd1, 16'h0007);
    res16("sub_equal", 16'h0000, 1'b1, 1'b1);

    // 16-bit multiply with ignored start/a_enable pulse mid-run.
    load16(16'hFFFF);
    op16(3'd5, 16'hFFFF);
    chk("mul_busy_start", 32'(if16.busy), 32'h1);
    chk("mul_done_start", 32'(if16.done), 32'h0);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      if (i == 8) begin
        if16.start = 1'b1; if16.a_enable = 1'b1; if16.a = 16'h0000;
        if16.op = 3'd0; if16.b = 16'h0000;
      end
      tick();
      if16.start = 1'b0; if16.a_enable = 1'b0;
      if (!(if16.busy === 1'b1 && if16.done === 1'b0)) bad++;
    end
    chk("mul_busy_run", 32'(bad), 32'd0);
    tick();
    res16("mul16", 16'hFFFE, 1'b1, 1'b0);
    chk("mul16_low", 32'(if16.mul_acc_out), 32'h0001);
    chk("mul16_busy_end", 32'(if16.busy), 32'h0);

    // a_reg still 0xFFFF: the mid-run load was dropped.
    op16(3'd0, 16'h0001);
    res16("add_after_mul", 16'h0000, 1'b1, 1'b1);

    load16(16'hF0F0);
    op16(3'd2, 16'hFF00);
    res16("xor", 16'h0FF0, 1'b0, 1'b0);
    op16(3'd3, 16'hFF00);
    res16("and", 16'hF000, 1'b0, 1'b0);
    op16(3'd4, 16'hFF00);
    res16("or", 16'hFFF0, 1'b0, 1'b0);
    chk("logic_mul_keep", 32'(if16.mul_acc_out), 32'h0001);

    // Load and start together: op sees old a_reg.
    if16.a = 16'h1234; if16.a_enable = 1'b1;
    op16(3'd0, 16'h0000);
    if16.a_enable = 1'b0;
    res16("load_start_old", 16'hF0F0, 1'b0, 1'b0);
    op16(3'd0, 16'h0000);
    res16("load_start_new", 16'h1234, 1'b0, 1'b0);

    op16(3'd6, 16'h5555);
    res16("nop", 16'h1234, 1'b0, 1'b0);

    // Reset eight edges after MUL start.
    load16(16'h0003);
    op16(3'd5, 16'h0005);
    for (int i = 1; i < 8; i++) tick();
    chk("mid_busy_pre", 32'(if16.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(if16.busy), 32'h0);
    chk("mid_rst_done", 32'(if16.done), 32'h0);
    chk("mid_rst_acc", 32'(if16.acc_out), 32'h0);
    chk("mid_rst_mul", 32'(if16.mul_acc_out), 32'h0);
    chk("mid_rst_carry", 32'(if16.carry), 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if16.done !== 1'b0) n++;
    end
    chk("mid_rst_no_done", 32'(n), 32'd0);

    // 8-bit instance: latency, result split, back-to-back ops.
    if8.a = 8'h0F; if8.a_enable = 1'b1;
    tick();
    if8.a_enable = 1'b0;
    if8.op = 3'd5; if8.b = 8'h11; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    n = 0;
    while (if8.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("mul8_latency", 32'(n), 32'd8);
    chk("mul8_acc", 32'(if8.acc_out), 32'h00);
    chk("mul8_low", 32'(if8.mul_acc_out), 32'hFF);
    chk("mul8_carry", 32'(if8.carry), 32'h0);
    chk("mul8_zero", 32'(if8.zero), 32'h1);
    chk("mul8_busy", 32'(if8.busy), 32'h0);

    // Issued in the done cycle: ADD uses a_reg=0x0F while 0x80 loads.
    if8.a = 8'h80; if8.a_enable = 1'b1;
    if8.op = 3'd0; if8.b = 8'h80; if8.start = 1'b1;
    tick();
    if8.a_enable = 1'b0;
    if8.start = 1'b0;
    chk("b2b_done", 32'(if8.done), 32'h1);
    chk("b2b_acc", 32'(if8.acc_out), 32'h8F);
    chk("b2b_carry", 32'(if8.carry), 32'h0);
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    chk("add8_acc", 32'(if8.acc_out), 32'h00);
    chk("add8_carry", 32'(if8.carry), 32'h1);
    chk("add8_zero", 32'(if8.zero), 32'h1);
    chk("add8_mul_keep", 32'(if8.mul_acc_out), 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_alu.md
# param_alu

Parametrised, multi-mode accumulator ALU for the datapath; successor to the fixed 16-bit add/sub/xor/multiply unit. Holds a loadable A operand register, computes ADD/SUB/XOR/AND/OR in one cycle and an unsigned WIDTH×WIDTH multiply iteratively (shift-add, one bit per cycle) behind a start/busy/done handshake. Results land in the accumulator (high half for MUL) and the multiply-low accumulator. Sits between the register file (operand source) and the writeback path.

## Interface
- WIDTH, 16, operand/accumulator width; legal values ≥ 4.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  A operand; loaded into a_reg when a_enable is high.
- a_enable  input  1  load a_reg; honoured only when busy = 0.
- b  input  WIDTH  B operand; sampled on the start edge.
- op  input  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 MUL, 110/111 NOP.
- start  input  1  begin op; honoured only when busy = 0.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse on completion of any accepted op.
- acc_out  output  WIDTH  accumulator (result / MUL high half).
- mul_acc_out  output  WIDTH  MUL low half; unchanged by non-MUL ops.
- zero  output  1  acc_out == 0 after last write.
- carry  output  1  ADD carry-out; SUB no-borrow (1 when a_reg ≥ b); MUL 1 when high half ≠ 0; 0 for logic ops.

## Operation
- States: IDLE, MUL. Reset → IDLE.
- IDLE, start = 1, op ∈ {ADD,SUB,XOR,AND,OR}: result from a_reg (pre-edge value) and b; acc_out, zero, carry written on that edge; stays IDLE.
- SUB = a_reg + ~b + 1; carry = adder carry-out. Sums truncated to WIDTH.
- NOP: no register change except done pulse.
- IDLE, start = 1, op = MUL: latch a_reg as multiplicand, b as multiplier, clear 2·WIDTH product and bit counter; → MUL; busy = 1.
- MUL: each edge adds multiplicand·(current multiplier bit) into the product and advances the counter; after WIDTH steps write product[2W-1:W] → acc_out, product[W-1:0] → mul_acc_out, zero/carry per table; → IDLE.
- a_enable and start together in IDLE: op uses old a_reg; new a loaded on the same edge.
- start or a_enable while busy: ignored, no queuing.
- op and b ignored after the start edge.

## Timing
- Reset: acc_out, mul_acc_out, a_reg, zero, carry, busy, done = 0; state IDLE. The registered zero flag resets to 0, not recomputed from acc_out.
- Single-cycle op: start sampled at edge k; results visible after edge k; done high during cycle k→k+1 only.
- MUL: start sampled at edge k; busy high from edge k through edge k+WIDTH; results and done=1 after edge k+WIDTH; busy=0 in the same cycle done=1; latency WIDTH cycles.
- New start accepted in the same cycle done is high (back-to-back ops).
- rst during MUL: aborts immediately; all outputs to reset values; no done pulse.
- rst has priority over start and a_enable.

## Test plan
- Reset: drive rst 2 cycles with start=1, a_enable=1 → all outputs 0, busy 0, done 0.
- ADD, WIDTH=16: a_reg=0xFFFF, b=0x0001 → acc_out 0x0000, carry 1, zero 1, done 1 cycle after start; a_reg=0x7FFF, b=0x0001 → 0x8000, carry 0, zero 0.
- SUB/logic: a_reg=5, b=7 SUB → 0xFFFE, carry 0; a_reg=7, b=7 SUB → 0, carry 1, zero 1; a_reg=0xF0F0, b=0xFF00 XOR → 0x0FF0, AND → 0xF000, OR → 0xFFF0, carry 0, mul_acc_out unchanged.
- MUL, WIDTH=16: 0xFFFF × 0xFFFF → acc_out 0xFFFE, mul_acc_out 0x0001, carry 1; busy 16 cycles; done exactly 16 edges after start; start and a_enable pulsed mid-run have no effect.
- Reset mid-MUL: assert rst 8 cycles after MUL start → outputs 0, busy 0, no done.
- WIDTH=8 instance: 0x0F × 0x11 → acc_out 0x00, mul_acc_out 0xFF, carry 0, zero 1, done 8 cycles after start; then immediate ADD 0x80+0x80 → 0x00, carry 1.
